// File: rtl/fir_pkg.sv
// fir_pkg: FSM state encoding, default widths and output saturation limits
// shared by fir_core and fir_mac.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_OUT_W  = 16;
  localparam int FIR_ADDR_W = 13;
  localparam int FIR_TAPS   = 16;
  localparam int FIR_FRAC   = 15;
  localparam int FIR_ACC_W  = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fir_state_e;

  // Largest and smallest two's-complement values representable in out_w bits.
  function automatic longint sat_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate; clr wins over en, result is registered
// so acc reflects the operands of the previous cycle.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ACC_W  = FIR_ACC_W
) (
  input  logic                     a_clk,
  input  logic                     a_rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int P_W = DATA_W + COEF_W;

  logic signed [P_W-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic signed [ACC_W-1:0] acc_r;

  // Full-precision product, then the next accumulator value.
  always_comb begin
    prod_s = P_W'(sample) * P_W'(coef);
    if (clr) begin
      acc_nxt_s = '0;
    end else if (en) begin
      acc_nxt_s = acc_r + ACC_W'(prod_s);
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Accumulator register.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      acc_r <= '0;
    end else begin
      acc_r <= acc_nxt_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/fir_core.sv
// fir_core: reads samples from the input RAM, runs a TAPS-long direct-form FIR
// and writes each result to the same index of the output RAM.
// Define FIR_SATURATE_EN to clip results to the OUT_W range instead of wrapping.
module fir_core
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int OUT_W  = FIR_OUT_W,
  parameter int ADDR_W = FIR_ADDR_W,
  parameter int TAPS   = FIR_TAPS,
  parameter int FRAC   = FIR_FRAC,
  parameter int ACC_W  = FIR_ACC_W
) (
  input  logic                     a_clk,
  input  logic                     a_rst,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_samples,
  output logic                     busy,
  output logic                     done,
  input  logic                     coef_wr,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [ADDR_W-1:0]        f_address_in,
  input  logic [DATA_W-1:0]        f_data_in,
  output logic                     f_wr,
  output logic [ADDR_W-1:0]        f_address_out,
  output logic [OUT_W-1:0]         f_data_out
);

  localparam int KW    = $clog2(TAPS);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [KW-1:0]    K_LAST  = KW'(TAPS - 1);
  localparam logic [KW-1:0]    K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] N_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  fir_state_e               state_r, state_nxt_s;
  logic [ADDR_W-1:0]        n_r, n_nxt_s;
  logic [KW-1:0]            k_r, k_nxt_s, k_d_r;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic                     mac_clr_s, tap_ok_s, tap_vld_r, tap_vld_d_r;
  logic                     busy_r, done_r, f_wr_r;
  logic [ADDR_W-1:0]        f_address_in_r, f_address_out_r;
  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic signed [ACC_W-1:0]  acc_s, shifted_s;
  logic [OUT_W-1:0]         result_s;

  // Next-state, counter and accumulator-clear decode.
  always_comb begin
    state_nxt_s = state_r;
    n_nxt_s     = n_r;
    k_nxt_s     = k_r;
    cnt_nxt_s   = cnt_r;
    mac_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt_s = (num_samples > CNT_MAX) ? CNT_MAX : num_samples;
          n_nxt_s   = '0;
          k_nxt_s   = '0;
          if (num_samples == '0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ISSUE;
            mac_clr_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          k_nxt_s = k_r + K_ONE;
        end
      end
      ST_DRAIN: state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (({1'b0, n_r} + CNT_ONE) < cnt_r) begin
          n_nxt_s     = n_r + N_ONE;
          k_nxt_s     = '0;
          mac_clr_s   = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Taps reaching back before sample 0 contribute zero and skip the RAM read.
  assign tap_ok_s = ({{(ADDR_W-KW){1'b0}}, k_nxt_s} <= n_nxt_s);

  // FSM, counters, read pipeline and registered outputs.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_r         <= ST_IDLE;
      n_r             <= '0;
      k_r             <= '0;
      k_d_r           <= '0;
      cnt_r           <= '0;
      tap_vld_r       <= 1'b0;
      tap_vld_d_r     <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      f_wr_r          <= 1'b0;
      f_address_in_r  <= '0;
      f_address_out_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      n_r         <= n_nxt_s;
      k_r         <= k_nxt_s;
      cnt_r       <= cnt_nxt_s;
      k_d_r       <= k_r;
      tap_vld_r   <= (state_nxt_s == ST_ISSUE) && tap_ok_s;
      tap_vld_d_r <= tap_vld_r;
      busy_r      <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN) ||
                     (state_nxt_s == ST_WRITE);
      done_r      <= (state_nxt_s == ST_DONE);
      f_wr_r      <= (state_nxt_s == ST_WRITE);
      if ((state_nxt_s == ST_ISSUE) && tap_ok_s) begin
        f_address_in_r <= n_nxt_s - {{(ADDR_W-KW){1'b0}}, k_nxt_s};
      end
      if (state_nxt_s == ST_WRITE) begin
        f_address_out_r <= n_nxt_s;
      end
    end
  end

  // Coefficient bank, writable only while idle.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < TAPS; i++) coef_r[i] <= '0;
    end else if (coef_wr && (state_r == ST_IDLE)) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_clk  (a_clk),
    .a_rst  (a_rst),
    .clr    (mac_clr_s),
    .en     (tap_vld_d_r),
    .sample (f_data_in),
    .coef   (coef_r[k_d_r]),
    .acc    (acc_s)
  );

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(OUT_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(OUT_W));

  // Scale the accumulator and clip into the output range.
  always_comb begin
    shifted_s = acc_s >>> FRAC;
    if (shifted_s > SAT_HI) begin
      result_s = SAT_HI[OUT_W-1:0];
    end else if (shifted_s < SAT_LO) begin
      result_s = SAT_LO[OUT_W-1:0];
    end else begin
      result_s = shifted_s[OUT_W-1:0];
    end
  end
`else
  logic acc_hi_unused_s;

  // Scale the accumulator and keep the low OUT_W bits.
  always_comb begin
    shifted_s = acc_s >>> FRAC;
    result_s  = shifted_s[OUT_W-1:0];
  end

  assign acc_hi_unused_s = ^shifted_s[ACC_W-1:OUT_W];
`endif

  // The accumulator is final and stable for the whole WRITE cycle.
  assign f_data_out    = result_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign f_wr          = f_wr_r;
  assign f_address_in  = f_address_in_r;
  assign f_address_out = f_address_out_r;

endmodule

// File: tb/tb_fir_core.sv
// tb_fir_core: table vectors, hand-written corner sequences and randomized
// runs against a behavioural FIR model for fir_core.
`timescale 1ns/1ps
module tb_fir_core;

  localparam int TAPS   = 16;
  localparam int FRAC   = 15;
  localparam int ADDR_W = 13;
  localparam int STEP   = TAPS + 2;
  localparam int LIMIT  = 1000;

  logic              a_clk = 1'b0;
  logic              a_rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_samples = '0;
  logic              busy, done, f_wr;
  logic              coef_wr = 1'b0;
  logic [3:0]        coef_addr = 4'd0;
  logic [15:0]       coef_data = 16'd0;
  logic [ADDR_W-1:0] f_address_in, f_address_out;
  logic [15:0]       f_data_in, f_data_out;

  logic [15:0] in_ram  [64];
  logic [15:0] out_ram [64];
  logic        cnt_clr = 1'b0;
  int          wr_cnt;
  int          h_m [TAPS];
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    int h0;
    int h1;
    int x [3];
    int y [3];
  } vec_t;

  vec_t tbl [4];

  fir_core dut (
    .a_clk         (a_clk),
    .a_rst         (a_rst),
    .start         (start),
    .num_samples   (num_samples),
    .busy          (busy),
    .done          (done),
    .coef_wr       (coef_wr),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .f_address_in  (f_address_in),
    .f_data_in     (f_data_in),
    .f_wr          (f_wr),
    .f_address_out (f_address_out),
    .f_data_out    (f_data_out)
  );

  always #5 a_clk = ~a_clk;

  // Input RAM: one-cycle read latency.
  always @(posedge a_clk) f_data_in <= in_ram[f_address_in[5:0]];

  // Output RAM capture and write counter.
  always @(posedge a_clk) begin
    if (cnt_clr) begin
      wr_cnt <= 0;
      for (int i = 0; i < 64; i++) out_ram[i] <= 16'h5A5A;
    end else if (f_wr) begin
      wr_cnt <= wr_cnt + 1;
      out_ram[f_address_out[5:0]] <= f_data_out;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: y[n] = sum h[k]*x[n-k], scaled, then wrapped or clipped.
  function automatic int ref_y(int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0) acc += longint'(h_m[k]) * longint'($signed(in_ram[n-k]));
    acc = acc >>> FRAC;
`ifdef FIR_SATURATE_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`else
    acc = longint'($signed(acc[15:0]));
`endif
    return int'(acc);
  endfunction

  task automatic load_coefs();
    logic [31:0] t;
    for (int k = 0; k < TAPS; k++) begin
      @(negedge a_clk);
      t         = h_m[k];
      coef_wr   = 1'b1;
      coef_addr = 4'(k);
      coef_data = t[15:0];
    end
    @(negedge a_clk);
    coef_wr = 1'b0;
  endtask

  // Start a run and count cycles to the done pulse; at cycle 'poke' pulse
  // start and a coefficient write while busy.
  task automatic run_job(input int num, input int poke, output int cyc);
    @(negedge a_clk);
    num_samples = (ADDR_W+1)'(num);
    start   = 1'b1;
    cnt_clr = 1'b1;
    @(negedge a_clk);
    start   = 1'b0;
    cnt_clr = 1'b0;
    cyc     = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (cyc == poke) begin
        start = 1'b1; coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 16'h4000;
      end else begin
        start = 1'b0; coef_wr = 1'b0;
      end
      @(negedge a_clk);
      cyc++;
    end
    start   = 1'b0;
    coef_wr = 1'b0;
    if (done !== 1'b1) check("done_timeout", cyc, -1);
  endtask

  task automatic compare_all(input string tag, input int num);
    check({tag, "_writes"}, wr_cnt, num);
    for (int n = 0; n < num; n++) check(tag, int'($signed(out_ram[n])), ref_y(n));
  endtask

  initial begin
    int cyc;
    int num;
    int w;

    tbl[0] = '{32767,  0,     '{100, -200, 32767},  '{99, -200, 32766}};
    tbl[1] = '{16384,  16384, '{1000, 2000, -4000}, '{500, 1500, -1000}};
    tbl[2] = '{-32768, 0,     '{5, -7, 32767},      '{-5, 7, -32767}};
    tbl[3] = '{0,      32767, '{300, -1, 50},       '{0, 299, -1}};

    for (int i = 0; i < 64; i++) in_ram[i] = 16'd0;

    // Reset state
    repeat (2) @(negedge a_clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_f_wr", int'(f_wr), 0);
    check("rst_addr_in", int'(f_address_in), 0);
    check("rst_addr_out", int'(f_address_out), 0);
    check("rst_data_out", int'(f_data_out), 0);
    a_rst = 1'b0;

    // Impulse response
    for (int k = 0; k < TAPS; k++) h_m[k] = 2 * (k + 1);
    load_coefs();
    in_ram[0] = 16'd16384;
    run_job(20, -1, cyc);
    check("impulse_cycles", cyc, 20 * STEP + 1);
    check("impulse_writes", wr_cnt, 20);
    for (int n = 0; n < 20; n++)
      check("impulse_out", int'($signed(out_ram[n])), (n < 16) ? n + 1 : 0);

    // Table vectors: two-tap filters over three samples
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < TAPS; k++) h_m[k] = 0;
      h_m[0] = tbl[r].h0;
      h_m[1] = tbl[r].h1;
      load_coefs();
      for (int i = 0; i < 3; i++) in_ram[i] = 16'(tbl[r].x[i]);
      run_job(3, -1, cyc);
      check("vec_cycles", cyc, 3 * STEP + 1);
      for (int i = 0; i < 3; i++) check("vec_out", int'($signed(out_ram[i])), tbl[r].y[i]);
    end

    // Ignored start/coef write while busy, then back-to-back rerun
    for (int k = 0; k < TAPS; k++) h_m[k] = 0;
    h_m[0] = 32767;
    load_coefs();
    for (int i = 0; i < 3; i++) in_ram[i] = 16'(tbl[0].x[i]);
    run_job(3, 10, cyc);
    check("busy_poke_cycles", cyc, 3 * STEP + 1);
    for (int i = 0; i < 3; i++) check("busy_poke_out", int'($signed(out_ram[i])), tbl[0].y[i]);
    run_job(3, -1, cyc);
    check("b2b_cycles", cyc, 3 * STEP + 1);
    check("b2b_writes", wr_cnt, 3);
    for (int i = 0; i < 3; i++) check("b2b_out", int'($signed(out_ram[i])), tbl[0].y[i]);

    // Saturation corner
    for (int k = 0; k < TAPS; k++) h_m[k] = 32767;
    load_coefs();
    for (int i = 0; i < 16; i++) in_ram[i] = 16'h7FFF;
`ifdef FIR_SATURATE_EN
    run_job(16, -1, cyc);
    check("sat_out15", int'(out_ram[15]), 32'h7FFF);
`else
    run_job(16, -1, cyc);
    check("sat_out15", int'(out_ram[15]), 32'hFFE0);
`endif
    compare_all("sat_model", 16);

    // Zero sample count
    run_job(0, -1, cyc);
    check("zero_cycles", cyc, 1);
    check("zero_writes", wr_cnt, 0);

    // Reset during ISSUE of sample 3
    for (int i = 0; i < 8; i++) in_ram[i] = 16'(1000 * (i + 1));
    @(negedge a_clk);
    num_samples = 14'd6; start = 1'b1; cnt_clr = 1'b1;
    @(negedge a_clk);
    start = 1'b0; cnt_clr = 1'b0;
    w = 0;
    while (wr_cnt < 3 && w < LIMIT) begin
      @(negedge a_clk);
      w++;
    end
    check("midrun_reached", int'(wr_cnt >= 3), 1);
    repeat (4) @(negedge a_clk);
    check("midrun_busy", int'(busy), 1);
    a_rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_f_wr", int'(f_wr), 0);
    check("arst_addr_in", int'(f_address_in), 0);
    check("arst_data_out", int'(f_data_out), 0);
    @(negedge a_clk);
    a_rst = 1'b0;
    run_job(4, -1, cyc);
    check("post_rst_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) check("post_rst_out", int'($signed(out_ram[i])), 0);

    // Randomized runs against the reference model
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < TAPS; k++) h_m[k] = int'($urandom_range(65535)) - 32768;
      load_coefs();
      for (int i = 0; i < 64; i++) in_ram[i] = 16'($urandom);
      num = int'($urandom_range(40, 1));
      run_job(num, -1, cyc);
      check("rand_cycles", cyc, num * STEP + 1);
      compare_all("rand_out", num);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_core.md
Name: fir_core

Overview:
- Processing engine between the input sample RAM and the output result RAM.
- Started by a control pulse. Reads num_samples 16-bit samples from the input RAM port, computes a direct-form FIR with TAPS coefficients held in an internal register bank, and writes each result to the same index in the output RAM.
- The AXI slave fills the input RAM beforehand and reads the output RAM afterwards.

Parameters:
- DATA_W, 16, input sample width (signed).
- COEF_W, 16, coefficient width (signed).
- OUT_W, 16, result width written to output RAM (signed).
- ADDR_W, 13, RAM address width (both RAMs).
- TAPS, 16, number of coefficients, power of two, >=2.
- FRAC, 15, right shift applied to the accumulator before output.
- ACC_W, 40, accumulator width; must satisfy ACC_W >= DATA_W+COEF_W+log2(TAPS).

Ports:
- a_clk  in  1  clock.
- a_rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins filtering when idle.
- num_samples  in  ADDR_W+1  sample count; sampled on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last result is written.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index.
- coef_data  in  COEF_W  coefficient value.
- f_address_in  out  ADDR_W  input RAM read address; data returns 1 cycle later.
- f_data_in  in  DATA_W  input RAM read data.
- f_wr  out  1  output RAM write enable.
- f_address_out  out  ADDR_W  output RAM write address.
- f_data_out  out  OUT_W  output RAM write data.

Behaviour:
- Reset (any time, including mid-run):
  - FSM returns to IDLE.
  - busy, done, f_wr = 0; f_address_in, f_address_out, f_data_out = 0.
  - Accumulator, counters and all coefficients = 0.
- Arithmetic:
  - y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k], with x[m]=0 for m<0. All operands signed two's complement; products sign-extended to ACC_W.
- Coefficients:
  - Written on coef_wr in IDLE only; coef_wr while busy is ignored.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
  - IDLE: start=1 latches num_samples, clears n. If num_samples=0, go to DONE; else clear acc and k, go to ISSUE. start while busy is ignored.
  - ISSUE: one tap per cycle, k=0..TAPS-1. If n-k>=0, drive f_address_in=n-k and mark the tap valid; else mark the tap as zero (no read needed). Accumulation uses a one-cycle-delayed valid/k pipeline: acc += h[k_d]*f_data_in when valid_d, else adds 0. After k=TAPS-1, go to DRAIN.
  - DRAIN: one cycle to accumulate the last tap.
  - WRITE: f_wr=1, f_address_out=n, f_data_out=result (acc >>> FRAC, arithmetic shift, then narrowed to OUT_W). Then either n+1<num_samples: n++, acc=0, k=0, go to ISSUE; or go to DONE.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, go to IDLE.
- Timing:
  - Throughput: TAPS+2 cycles per output sample.
  - Start-to-first-write: TAPS+2 cycles after the start edge.
  - Total run: num_samples*(TAPS+2)+1 cycles to the done pulse.
- Boundary conditions:
  - num_samples = 2^ADDR_W: n addresses 0..2^ADDR_W-1, no wrap.
  - Values above 2^ADDR_W are clamped to 2^ADDR_W.
  - f_wr is high only in WRITE. f_address_in holds its last value outside ISSUE.

Optional Feature:
- Macro FIR_SATURATE_EN.
- Defined: the shifted accumulator saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the low OUT_W bits are taken (wrap-around). No other behaviour changes.

Decomposition:
- Package fir_pkg: FSM state enum, default widths, and saturation limit constants.
- One natural sub-module, fir_mac: registered multiply-accumulate.
  - Inputs: clr, en, sample, coef.
  - Output: acc.
  - Zero added cycles of latency beyond the one-cycle RAM delay.

Test Plan:
- Impulse response: h[k]=k+1 (k=0..15), FRAC=0, x[0]=1, rest 0, num_samples=20 -> out[n]=n+1 for n<16, 0 for n=16..19; done after 20*18+1 cycles.
- Identity: h[0]=0x7FFF, others 0, FRAC=15, x=[100,-200,32767] -> out=[99,-200,32766].
- Saturation: all h=0x7FFF, x all 0x7FFF, FRAC=15, n=15 -> with FIR_SATURATE_EN out=32767; without it, low 16 bits of the 16*32766 sum, i.e. 0xFFE0.
- Zero count plus ignored writes: start with num_samples=0 -> done one cycle after start, f_wr never asserted. coef_wr during busy -> coefficient unchanged.
- Reset mid-run: assert a_rst during ISSUE of sample 3 -> busy=0, f_wr=0, coefficients=0 immediately (async); a new start after release gives all-zero outputs.
- Back-to-back: start pulsed again while busy -> ignored. A second start one cycle after done -> a complete second run with identical results.
